// File: rtl/mod_b_pkg.sv
// rtl/mod_b_pkg.sv - shared types and defaults for the mod_b downstream counter stage
package mod_b_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } b_state_t;

   localparam int DEF_W         = 4;
   localparam int DEF_START_VAL = 1;

endpackage

// File: rtl/trg_pend_buf.sv
// rtl/trg_pend_buf.sv - one-entry pending trigger buffer with overflow flag
module trg_pend_buf #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] data_in,
   output logic         valid,
   output logic [W-1:0] data_out,
   output logic         overflow
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // A push only overflows when the entry is full and not being drained this cycle.
   assign overflow = push && r_valid && !pop;
   assign valid    = r_valid;
   assign data_out = r_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (push && (!r_valid || pop)) begin
         r_valid <= 1'b1;
         r_data  <= data_in;
      end else if (pop) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mod_b.sv
// rtl/mod_b.sv - downstream run counter triggered by count_a's ok pulse
module mod_b
   import mod_b_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int START_VAL = DEF_START_VAL
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         trg_b,
   input  logic [W-1:0] val_a,
   output logic [W-1:0] count_b,
   output logic         busy,
   output logic         done,
   output logic         drop_err
);

   localparam logic [W-1:0] START_W = W'(START_VAL);

   b_state_t     r_state;
   logic [W-1:0] r_count;
   logic [W-1:0] r_target;
   logic         r_drop_err;

   logic         w_push;
   logic         w_pop;
   logic         w_pend_valid;
   logic [W-1:0] w_pend_data;
   logic         w_overflow;

   assign w_push = trg_b && (r_state != IDLE);
   assign w_pop  = (r_state == DONE) && w_pend_valid;

   trg_pend_buf #(
      .W (W)
   ) u_pend (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push),
      .pop      (w_pop),
      .data_in  (val_a),
      .valid    (w_pend_valid),
      .data_out (w_pend_data),
      .overflow (w_overflow)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_target   <= '0;
         r_drop_err <= 1'b0;
      end else begin
         if (w_overflow)
            r_drop_err <= 1'b1;
         case (r_state)
            IDLE: begin
               if (trg_b) begin
                  r_target <= val_a;
                  if (val_a == '0) begin
                     r_state <= DONE;
                  end else begin
                     r_state <= RUN;
                     r_count <= START_W;
                  end
               end
            end
            RUN: begin
               if (r_count == r_target)
                  r_state <= DONE;
               else
                  r_count <= r_count + 1'b1;
            end
            DONE: begin
               // A zero-length pending run re-enters DONE for a back-to-back pulse.
               if (w_pend_valid) begin
                  r_target <= w_pend_data;
                  if (w_pend_data == '0) begin
                     r_state <= DONE;
                  end else begin
                     r_state <= RUN;
                     r_count <= START_W;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign count_b  = r_count;
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign drop_err = r_drop_err;

endmodule
